// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece encoding, dispatcher state and response codes for the move checker interface
package chess_pkg;

    typedef enum logic [2:0] {
        PK_EMPTY  = 3'd0,
        PK_PAWN   = 3'd1,
        PK_KNIGHT = 3'd2,
        PK_BISHOP = 3'd3,
        PK_ROOK   = 3'd4,
        PK_QUEEN  = 3'd5,
        PK_KING   = 3'd6,
        PK_RSVD   = 3'd7
    } piece_kind_t;

    // color 0 = white, 1 = black
    typedef struct packed {
        logic        color;
        piece_kind_t kind;
    } piece_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRECHECK = 2'd1,
        WAIT     = 2'd2,
        RESPOND  = 2'd3
    } dispatch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PRECHECK = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } rsp_err_t;

    function automatic logic [2:0] abs_diff3(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/move_check_dispatcher.sv
// rtl/move_check_dispatcher.sv - issues one move to a piece checker per request and returns its verdict
module move_check_dispatcher
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            old_x,
    input  logic [2:0]            old_y,
    input  logic [2:0]            new_x,
    input  logic [2:0]            new_y,
    input  logic                  side_to_move,
    input  logic [7:0][7:0][3:0]  board_in,
    output logic                  chk_reset_n,
    output logic [2:0]            chk_old_x,
    output logic [2:0]            chk_old_y,
    output logic [2:0]            chk_new_x,
    output logic [2:0]            chk_new_y,
    output logic [2:0]            chk_h_delta,
    output logic [2:0]            chk_v_delta,
    output logic [3:0]            chk_piece_type,
    input  logic                  chk_valid_move,
    input  logic                  chk_valid_output,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_legal,
    output logic [1:0]            rsp_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    dispatch_state_t state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic            side_q;
    piece_t          src_piece;
    piece_t          dst_piece;
    logic            precheck_fail;
    logic            timer_last;

    // The source piece is taken from the latched type; the destination is read
    // live because the board is held stable for the whole transaction.
    assign src_piece  = piece_t'(chk_piece_type);
    assign dst_piece  = piece_t'(board_in[chk_new_x][chk_new_y]);
    assign timer_last = (timer_q == TIMER_LAST);

    always_comb begin
        precheck_fail = 1'b0;
        if (src_piece.kind == PK_EMPTY)
            precheck_fail = 1'b1;
        if (src_piece.color != side_q)
            precheck_fail = 1'b1;
        if ((chk_old_x == chk_new_x) && (chk_old_y == chk_new_y))
            precheck_fail = 1'b1;
        if ((dst_piece.kind != PK_EMPTY) && (dst_piece.color == side_q))
            precheck_fail = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = PRECHECK;
            end
            PRECHECK: begin
                state_d = precheck_fail ? RESPOND : WAIT;
            end
            WAIT: begin
                if (chk_valid_output || timer_last)
                    state_d = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_reset_n    <= 1'b0;
            chk_old_x      <= 3'd0;
            chk_old_y      <= 3'd0;
            chk_new_x      <= 3'd0;
            chk_new_y      <= 3'd0;
            chk_h_delta    <= 3'd0;
            chk_v_delta    <= 3'd0;
            chk_piece_type <= 4'd0;
            side_q         <= 1'b0;
            timer_q        <= '0;
            rsp_valid      <= 1'b0;
            rsp_legal      <= 1'b0;
            rsp_err        <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        chk_old_x      <= old_x;
                        chk_old_y      <= old_y;
                        chk_new_x      <= new_x;
                        chk_new_y      <= new_y;
                        chk_h_delta    <= abs_diff3(new_x, old_x);
                        chk_v_delta    <= abs_diff3(new_y, old_y);
                        chk_piece_type <= board_in[old_x][old_y];
                        side_q         <= side_to_move;
                    end
                end
                PRECHECK: begin
                    timer_q <= '0;
                    if (precheck_fail) begin
                        rsp_valid <= 1'b1;
                        rsp_legal <= 1'b0;
                        rsp_err   <= ERR_PRECHECK;
                    end else begin
                        chk_reset_n <= 1'b1;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A verdict arriving on the final cycle still beats the timeout.
                    if (chk_valid_output) begin
                        chk_reset_n <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_legal   <= chk_valid_move;
                        rsp_err     <= chk_valid_move ? ERR_NONE : ERR_ILLEGAL;
                    end else if (timer_last) begin
                        chk_reset_n <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_legal   <= 1'b0;
                        rsp_err     <= ERR_TIMEOUT;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_legal <= 1'b0;
                        rsp_err   <= ERR_NONE;
                    end
                end
                default: begin
                    chk_reset_n <= 1'b0;
                    rsp_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_check_dispatcher.sv
// tb/tb_move_check_dispatcher.sv - randomized and directed self-checking bench for move_check_dispatcher
module tb_move_check_dispatcher;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic                 clk;
    logic                 reset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic                 side_to_move;
    logic [7:0][7:0][3:0] board_in;
    logic                 chk_reset_n;
    logic [2:0]           chk_old_x, chk_old_y, chk_new_x, chk_new_y;
    logic [2:0]           chk_h_delta, chk_v_delta;
    logic [3:0]           chk_piece_type;
    logic                 chk_valid_move;
    logic                 chk_valid_output;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_legal;
    logic [1:0]           rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    // Checker stub: answers a fixed number of cycles after its reset is released.
    int chk_cnt = 0;
    int chk_lat = NEVER;
    bit chk_verdict = 1'b0;
    bit use_geom = 1'b0;

    move_check_dispatcher #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .old_x            (old_x),
        .old_y            (old_y),
        .new_x            (new_x),
        .new_y            (new_y),
        .side_to_move     (side_to_move),
        .board_in         (board_in),
        .chk_reset_n      (chk_reset_n),
        .chk_old_x        (chk_old_x),
        .chk_old_y        (chk_old_y),
        .chk_new_x        (chk_new_x),
        .chk_new_y        (chk_new_y),
        .chk_h_delta      (chk_h_delta),
        .chk_v_delta      (chk_v_delta),
        .chk_piece_type   (chk_piece_type),
        .chk_valid_move   (chk_valid_move),
        .chk_valid_output (chk_valid_output),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_legal        (rsp_legal),
        .rsp_err          (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!chk_reset_n)
            chk_cnt <= 0;
        else
            chk_cnt <= chk_cnt + 1;
    end

    assign chk_valid_output = chk_reset_n && (chk_cnt == chk_lat);
    assign chk_valid_move   = use_geom ? ((chk_h_delta == chk_v_delta) && (chk_h_delta != 3'd0))
                                       : chk_verdict;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pre_ok(input int ox, input int oy, input int nx, input int ny,
                                        input bit side);
        int src;
        int dst;
        src = int'(board_in[ox][oy]);
        dst = int'(board_in[nx][ny]);
        if (src % 8 == 0) return 1'b0;
        if ((src / 8) != int'(side)) return 1'b0;
        if (ox == nx && oy == ny) return 1'b0;
        if ((dst % 8 != 0) && ((dst / 8) == int'(side))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_board();
        board_in = '0;
    endtask

    task automatic random_board();
        logic [3:0] p;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                p[3]   = 1'($urandom_range(1));
                p[2:0] = 3'($urandom_range(6, 1));
                board_in[x][y] = ($urandom_range(1) == 0) ? 4'h0 : p;
            end
        end
    endtask

    task automatic run_move(input int ox, input int oy, input int nx, input int ny, input bit side,
                            input int lat, input bit verdict, input bit geom, input int hold);
        int exp_lat, exp_hi, exp_legal, exp_err;
        int dx, dy, cyc, hi;
        bit ok, v;
        logic [2:0] ax, ay, bx, by, ddx, ddy;
        dx = (ox > nx) ? ox - nx : nx - ox;
        dy = (oy > ny) ? oy - ny : ny - oy;
        ok = model_pre_ok(ox, oy, nx, ny, side);
        v  = geom ? ((dx == dy) && (dx != 0)) : verdict;
        if (!ok) begin
            exp_lat = 2; exp_hi = 0; exp_legal = 0; exp_err = 1;
        end else if (lat < TIMEOUT) begin
            exp_lat = 3 + lat; exp_hi = lat + 1; exp_legal = int'(v); exp_err = v ? 0 : 2;
        end else begin
            exp_lat = 2 + TIMEOUT; exp_hi = TIMEOUT; exp_legal = 0; exp_err = 3;
        end
        chk_lat = lat; chk_verdict = verdict; use_geom = geom;
        ax = ox[2:0]; ay = oy[2:0]; bx = nx[2:0]; by = ny[2:0]; ddx = dx[2:0]; ddy = dy[2:0];

        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("req_ready_before", 32'(req_ready), 32'd1);
        old_x = ax; old_y = ay; new_x = bx; new_y = by; side_to_move = side;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        old_x = 3'($urandom); old_y = 3'($urandom); new_x = 3'($urandom); new_y = 3'($urandom);
        side_to_move = 1'($urandom);
        check("coords", 32'({chk_old_x, chk_old_y, chk_new_x, chk_new_y}), 32'({ax, ay, bx, by}));
        check("deltas", 32'({chk_h_delta, chk_v_delta}), 32'({ddx, ddy}));
        check("piece", 32'(chk_piece_type), 32'(board_in[ox][oy]));

        cyc = 1; hi = 0;
        while (!rsp_valid && cyc < 60) begin
            if (chk_reset_n) hi++;
            @(posedge clk); #1; cyc++;
        end
        check("latency", cyc, exp_lat);
        check("chk_release_cycles", hi, exp_hi);
        check("legal", 32'(rsp_legal), exp_legal);
        check("err", 32'(rsp_err), exp_err);
        check("chk_reset_n_in_rsp", 32'(chk_reset_n), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rsp_hold", 32'({rsp_valid, rsp_legal, rsp_err, req_ready}),
                  32'({1'b1, exp_legal[0], exp_err[1:0], 1'b0}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after_handshake", 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({req_ready, rsp_valid, rsp_legal, rsp_err, chk_reset_n}), 32'b100000);
        check({tag, "_regs"}, 32'({chk_old_x, chk_old_y, chk_new_x, chk_new_y}), 32'd0);
        check({tag, "_regs2"}, 32'({chk_h_delta, chk_v_delta, chk_piece_type}), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd0; side_to_move = 1'b0;
        board_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle", 32'({req_ready, rsp_valid, chk_reset_n}), 32'b100);
        end

        // Bishop diagonal with a geometric checker
        clear_board();
        board_in[2][0] = 4'h3;
        run_move(2, 0, 5, 3, 1'b0, 4, 1'b0, 1'b1, 0);
        // Non-diagonal bishop rejected by checker
        run_move(2, 0, 5, 2, 1'b0, 4, 1'b0, 1'b1, 0);
        // Empty source
        run_move(0, 0, 1, 1, 1'b0, 4, 1'b1, 1'b0, 0);
        // Own piece on destination, then a capture of an enemy piece
        board_in[5][3] = 4'h1;
        run_move(2, 0, 5, 3, 1'b0, 4, 1'b1, 1'b0, 0);
        board_in[5][3] = 4'h9;
        run_move(2, 0, 5, 3, 1'b0, 4, 1'b1, 1'b0, 0);
        // Same square; wrong side to move
        run_move(2, 0, 2, 0, 1'b0, 4, 1'b1, 1'b0, 0);
        run_move(2, 0, 4, 2, 1'b1, 4, 1'b1, 1'b0, 0);
        // Timeout, verdict on last cycle (legal and illegal), delayed consumer
        run_move(2, 0, 4, 2, 1'b0, NEVER, 1'b1, 1'b0, 0);
        run_move(2, 0, 4, 2, 1'b0, TIMEOUT - 1, 1'b1, 1'b0, 0);
        run_move(2, 0, 4, 2, 1'b0, TIMEOUT - 1, 1'b0, 1'b0, 0);
        run_move(2, 0, 4, 2, 1'b0, 0, 1'b1, 1'b0, 20);

        // Asynchronous reset while the checker is running
        chk_lat = NEVER;
        old_x = 3'd2; old_y = 3'd0; new_x = 3'd4; new_y = 3'd2; side_to_move = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_wait_released", 32'(chk_reset_n), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_move(2, 0, 7, 5, 1'b0, 2, 1'b1, 1'b0, 0);

        for (int t = 0; t < 150; t++) begin
            int ox, oy, nx, ny, lat;
            bit side;
            logic [3:0] p;
            random_board();
            side = 1'($urandom_range(1));
            ox = $urandom_range(7); oy = $urandom_range(7);
            nx = $urandom_range(7); ny = $urandom_range(7);
            if ($urandom_range(3) != 0) begin
                p[3] = side;
                p[2:0] = 3'($urandom_range(6, 1));
                board_in[ox][oy] = p;
            end
            if ($urandom_range(1) == 0 && !(nx == ox && ny == oy))
                board_in[nx][ny] = 4'h0;
            lat = $urandom_range(19);
            if (lat >= TIMEOUT) lat = NEVER;
            run_move(ox, oy, nx, ny, side, lat, 1'($urandom_range(1)), 1'b0, $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
